// File: rtl/somatorio_pkg.sv
// ----------------------------------------------------------------------------
// somatorio_pkg
// Shared definitions for the triangular-sum arbiter:
//   NW_DEFAULT - default width of the term count n
//   RW_DEFAULT - default width of the accumulated result
//   state_t    - controller states (IDLE, TEST, ACC, DONE)
// ----------------------------------------------------------------------------
package somatorio_pkg;

    localparam int NW_DEFAULT = 8;
    localparam int RW_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/somatorio_dp.sv
// ----------------------------------------------------------------------------
// somatorio_dp
// Down-counter plus accumulator computing n + (n-1) + ... + 1.
// Ports:
//   ck      - clock, rising edge
//   reset   - asynchronous, active-low reset
//   load    - load counter with load_n and clear the accumulator
//   load_n  - term count to load
//   dec     - decrement the counter
//   acc_en  - add the counter into the accumulator (modulo 2^RW)
//   zero    - counter is zero
//   carry   - carry out of the RW+1-bit sum acc + cnt
//   acc     - current accumulator value
// ----------------------------------------------------------------------------
module somatorio_dp
    import somatorio_pkg::*;
#(
    parameter int NW = NW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          ck,
    input  logic          reset,
    input  logic          load,
    input  logic [NW-1:0] load_n,
    input  logic          dec,
    input  logic          acc_en,
    output logic          zero,
    output logic          carry,
    output logic [RW-1:0] acc
);

    logic [NW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW:0]   sum;

    // The sum is one bit wider than the accumulator so the top bit is the
    // carry that flags a wrapped result.
    always_comb begin
        sum   = {1'b0, acc_q} + (RW+1)'(cnt_q);
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (load) begin
            cnt_d = load_n;
            acc_d = '0;
        end else begin
            if (dec) begin
                cnt_d = cnt_q - NW'(1);
            end
            if (acc_en) begin
                acc_d = sum[RW-1:0];
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign zero  = (cnt_q == '0);
    assign carry = sum[RW];
    assign acc   = acc_q;

endmodule

// File: rtl/somatorio_arbiter.sv
// ----------------------------------------------------------------------------
// somatorio_arbiter
// Two-requester round-robin arbiter in front of a serial 1+2+...+n adder.
// Ports:
//   ck, reset        - clock (rising edge), asynchronous active-low reset
//   req0/req1        - level requests, held until ack
//   n0/n1            - term count for each requester, stable while req high
//   ack0/ack1        - one-cycle pulse: request accepted, n captured
//   done0/done1      - one-cycle pulse: result valid for that requester
//   result           - last finished sum modulo 2^RW, held until next done
//   overflow         - last finished sum exceeded 2^RW-1, held with result
//   busy             - controller is not idle
// All outputs are registered.
// ----------------------------------------------------------------------------
module somatorio_arbiter
    import somatorio_pkg::*;
#(
    parameter int NW = NW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          ck,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [NW-1:0] n0,
    input  logic [NW-1:0] n1,
    output logic          ack0,
    output logic          ack1,
    output logic          done0,
    output logic          done1,
    output logic [RW-1:0] result,
    output logic          overflow,
    output logic          busy
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [RW-1:0] result_q, result_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;

    logic          grant;
    logic          load;
    logic          dec;
    logic          acc_en;
    logic          dp_zero;
    logic          dp_carry;
    logic [RW-1:0] dp_acc;
    logic [NW-1:0] load_n;

    // On a tie the requester that was not served last wins; last_q holds
    // the index of the requester served most recently.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_q;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    assign load_n = grant ? n1 : n0;

    somatorio_dp #(
        .NW (NW),
        .RW (RW)
    ) u_dp (
        .ck     (ck),
        .reset  (reset),
        .load   (load),
        .load_n (load_n),
        .dec    (dec),
        .acc_en (acc_en),
        .zero   (dp_zero),
        .carry  (dp_carry),
        .acc    (dp_acc)
    );

    // Next-state and registered-output logic. Pulses (ack/done) are computed
    // on the transition into the state in which they must be visible.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        load       = 1'b0;
        dec        = 1'b0;
        acc_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = TEST;
                    load    = 1'b1;
                    owner_d = grant;
                    ovf_d   = 1'b0;
                    ack0_d  = ~grant;
                    ack1_d  = grant;
                end
            end
            TEST: begin
                if (dp_zero) begin
                    state_d    = DONE;
                    result_d   = dp_acc;
                    overflow_d = ovf_q;
                    done0_d    = ~owner_q;
                    done1_d    = owner_q;
                    last_d     = owner_q;
                end else begin
                    state_d = ACC;
                end
            end
            ACC: begin
                dec    = 1'b1;
                acc_en = 1'b1;
                // Sticky for the whole job: one wrap is enough to flag it.
                if (dp_carry) begin
                    ovf_d = 1'b1;
                end
                state_d = TEST;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            ovf_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_somatorio_arbiter.sv
// ----------------------------------------------------------------------------
// tb_somatorio_arbiter
// Self-checking bench for somatorio_arbiter. A reference model predicts, from
// the requests it sees, which requester is accepted on which edge, when its
// done pulse appears and the sum/overflow it carries. A monitor compares the
// DUT outputs against those predictions on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_somatorio_arbiter;

    localparam int NW = 8;
    localparam int RW = 12;

    logic          ck    = 1'b0;
    logic          reset = 1'b1;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic [NW-1:0] n0    = '0;
    logic [NW-1:0] n1    = '0;
    logic          ack0;
    logic          ack1;
    logic          done0;
    logic          done1;
    logic [RW-1:0] result;
    logic          overflow;
    logic          busy;

    typedef struct {
        int k;
        int cyc;
        int res;
        int ovf;
    } exp_t;

    exp_t ack_q[$];
    exp_t done_q[$];
    int   hist_k[$];
    int   hist_res[$];

    int checks       = 0;
    int failures     = 0;
    int edge_cnt     = 0;
    int next_accept  = 0;
    int busy_end     = -1;
    int last_served  = 1;
    int done_total   = 0;
    int last_ack_cyc = 0;
    int last_latency = 0;
    int last_result  = 0;
    int last_ovf     = 0;
    int last_owner   = 0;

    somatorio_arbiter #(
        .NW (NW),
        .RW (RW)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .n0       (n0),
        .n1       (n1),
        .ack0     (ack0),
        .ack1     (ack1),
        .done0    (done0),
        .done1    (done1),
        .result   (result),
        .overflow (overflow),
        .busy     (busy)
    );

    // Free-running clock, period 10.
    always #5 ck = ~ck;

    // Absolute safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: an accept happens on the first rising edge on which the
    // controller is free and a request is present. The job then occupies the
    // block for 2n+2 cycles plus one idle cycle, and its result is the closed
    // form n(n+1)/2 wrapped to RW bits.
    initial begin : model_proc
        int   k;
        int   nn;
        int   total;
        exp_t e;
        forever begin
            @(posedge ck);
            edge_cnt++;
            if (reset && edge_cnt >= next_accept && (req0 || req1)) begin
                if (req0 && req1) begin
                    k = (last_served == 1) ? 0 : 1;
                end else begin
                    k = req1 ? 1 : 0;
                end
                nn    = (k == 1) ? int'(n1) : int'(n0);
                total = nn * (nn + 1) / 2;
                e.k   = k;
                e.cyc = edge_cnt;
                e.res = 0;
                e.ovf = 0;
                ack_q.push_back(e);
                e.cyc = edge_cnt + 2 * nn + 1;
                e.res = total % (1 << RW);
                e.ovf = (total > (1 << RW) - 1) ? 1 : 0;
                done_q.push_back(e);
                next_accept = edge_cnt + 2 * nn + 3;
                busy_end    = edge_cnt + 2 * nn + 1;
                last_served = k;
            end
        end
    end

    // Monitor: on every falling edge, match ack/done pulses against the
    // predicted queue and flag anything missing, extra or late.
    initial begin : monitor_proc
        exp_t e;
        int   got;
        forever begin
            @(negedge ck);
            if (reset) begin
                if (ack0 || ack1) begin
                    checkOutput("ack_exclusive", (ack0 && ack1) ? 1 : 0, 0);
                    got = ack1 ? 1 : 0;
                    if (ack_q.size() == 0) begin
                        checkOutput("ack_unexpected", 1, 0);
                    end else begin
                        e = ack_q.pop_front();
                        checkOutput("ack_owner", got, e.k);
                        checkOutput("ack_cycle", edge_cnt, e.cyc);
                    end
                    last_ack_cyc = edge_cnt;
                end else if (ack_q.size() > 0 && ack_q[0].cyc < edge_cnt) begin
                    checkOutput("ack_missing", 0, 1);
                    void'(ack_q.pop_front());
                end

                if (done0 || done1) begin
                    checkOutput("done_exclusive", (done0 && done1) ? 1 : 0, 0);
                    got = done1 ? 1 : 0;
                    if (done_q.size() == 0) begin
                        checkOutput("done_unexpected", 1, 0);
                    end else begin
                        e = done_q.pop_front();
                        checkOutput("done_owner", got, e.k);
                        checkOutput("done_cycle", edge_cnt, e.cyc);
                        checkOutput("done_result", int'(result), e.res);
                        checkOutput("done_overflow", int'(overflow), e.ovf);
                    end
                    last_latency = edge_cnt - last_ack_cyc;
                    last_result  = int'(result);
                    last_ovf     = int'(overflow);
                    last_owner   = got;
                    hist_k.push_back(got);
                    hist_res.push_back(int'(result));
                    done_total++;
                end else if (done_q.size() > 0 && done_q[0].cyc < edge_cnt) begin
                    checkOutput("done_missing", 0, 1);
                    void'(done_q.pop_front());
                end

                checkOutput("busy", int'(busy), (edge_cnt <= busy_end) ? 1 : 0);
            end
        end
    end

    // Asserts reset between edges, checks that every output clears at once,
    // drops any pending request and resynchronises the model.
    task automatic applyReset();
        @(posedge ck);
        #3;
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_ack0", int'(ack0), 0);
        checkOutput("rst_ack1", int'(ack1), 0);
        checkOutput("rst_done0", int'(done0), 0);
        checkOutput("rst_done1", int'(done1), 0);
        ack_q.delete();
        done_q.delete();
        next_accept = 0;
        busy_end    = -1;
        last_served = 1;
        repeat (2) @(negedge ck);
        #2;
        reset = 1'b1;
    endtask

    // Raises a request from requester k with term count n.
    task automatic applyStimulus(input int k, input int n);
        if (k == 0) begin
            req0 = 1'b1;
            n0   = NW'(n);
        end else begin
            req1 = 1'b1;
            n1   = NW'(n);
        end
    endtask

    // Behaves like well-mannered requesters (drop req on ack) until the done
    // count reaches target, with a cycle budget.
    task automatic runUntilDone(input int target, input int budget);
        for (int i = 0; i < budget && done_total < target; i++) begin
            @(negedge ck);
            #1;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        if (done_total < target) begin
            checkOutput("done_timeout", done_total, target);
        end
    endtask

    // Mostly short jobs, occasionally long enough to wrap the result.
    function automatic int pickN();
        if ($urandom_range(0, 15) == 0) begin
            return int'($urandom_range(90, 130));
        end
        return int'($urandom_range(0, 12));
    endfunction

    // Main sequence: directed scenarios first, then a randomized mix.
    initial begin : main_proc
        int base;
        int seen;

        applyReset();

        // Single job n=4 from requester 0.
        @(negedge ck); #1;
        applyStimulus(0, 4);
        runUntilDone(done_total + 1, 100);
        checkOutput("n4_latency", last_latency, 9);
        checkOutput("n4_result", last_result, 10);
        checkOutput("n4_overflow", last_ovf, 0);
        checkOutput("n4_owner", last_owner, 0);

        // Zero-length job from requester 1.
        @(negedge ck); #1;
        applyStimulus(1, 0);
        runUntilDone(done_total + 1, 100);
        checkOutput("n0_latency", last_latency, 1);
        checkOutput("n0_result", last_result, 0);
        checkOutput("n0_owner", last_owner, 1);

        // Tie right after reset: requester 0 first, then requester 1.
        applyReset();
        hist_k.delete();
        hist_res.delete();
        @(negedge ck); #1;
        applyStimulus(0, 3);
        applyStimulus(1, 5);
        runUntilDone(done_total + 2, 200);
        checkOutput("tie1_jobs", hist_k.size(), 2);
        if (hist_k.size() >= 2) begin
            checkOutput("tie1_first_owner", hist_k[0], 0);
            checkOutput("tie1_first_result", hist_res[0], 6);
            checkOutput("tie1_second_owner", hist_k[1], 1);
            checkOutput("tie1_second_result", hist_res[1], 15);
        end

        // Second tie: requester 1 was served last, so requester 0 wins.
        hist_k.delete();
        hist_res.delete();
        @(negedge ck); #1;
        applyStimulus(0, 1);
        applyStimulus(1, 2);
        runUntilDone(done_total + 2, 200);
        checkOutput("tie2_jobs", hist_k.size(), 2);
        if (hist_k.size() >= 2) begin
            checkOutput("tie2_first_owner", hist_k[0], 0);
            checkOutput("tie2_second_owner", hist_k[1], 1);
            checkOutput("tie2_second_result", hist_res[1], 3);
        end

        // Wrapping job followed by a small one that must clear overflow.
        @(negedge ck); #1;
        applyStimulus(0, 100);
        runUntilDone(done_total + 1, 400);
        checkOutput("n100_latency", last_latency, 201);
        checkOutput("n100_result", last_result, 954);
        checkOutput("n100_overflow", last_ovf, 1);
        @(negedge ck); #1;
        applyStimulus(0, 2);
        runUntilDone(done_total + 1, 100);
        checkOutput("n2_result", last_result, 3);
        checkOutput("n2_overflow", last_ovf, 0);

        // Reset in the middle of an n=10 job: aborted, no done, then recovery.
        @(negedge ck); #1;
        applyStimulus(0, 10);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge ck); #1;
            if (ack0) begin
                seen = 1;
                req0 = 1'b0;
            end
        end
        checkOutput("abort_ack_seen", seen, 1);
        checkOutput("abort_busy_before", int'(busy), 1);
        base = done_total;
        applyReset();
        repeat (30) @(negedge ck);
        checkOutput("abort_no_done", done_total - base, 0);
        #1;
        applyStimulus(0, 5);
        runUntilDone(done_total + 1, 100);
        checkOutput("recover_result", last_result, 15);
        checkOutput("recover_latency", last_latency, 11);

        // Randomized traffic: requesters raise, sometimes withdraw before ack,
        // and sometimes keep req high after ack so it counts as a new request.
        for (int c = 0; c < 3000; c++) begin
            @(negedge ck); #1;
            if (ack0) begin
                if ($urandom_range(0, 3) != 0) req0 = 1'b0;
            end else if (req0) begin
                if ($urandom_range(0, 19) == 0) req0 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                applyStimulus(0, pickN());
            end
            if (ack1) begin
                if ($urandom_range(0, 3) != 0) req1 = 1'b0;
            end else if (req1) begin
                if ($urandom_range(0, 19) == 0) req1 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1, pickN());
            end
        end

        // Drain whatever is still in flight.
        @(negedge ck); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 600 && (ack_q.size() > 0 || done_q.size() > 0); i++) begin
            @(negedge ck);
        end
        checkOutput("drain_acks", ack_q.size(), 0);
        checkOutput("drain_dones", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/somatorio_arbiter.md
SOMATORIO_ARBITER -- requirements
Module: somatorio_arbiter

Interface
REQ-001 Parameter NW, 8, width of the term count n.
REQ-002 Parameter RW, 12, width of the accumulated result.
REQ-003 ck  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1  level request from requester 0 / 1; held until ack.
REQ-006 n0 / n1  input  NW  term count of the requested sum 1+2+...+n; held stable while req is high.
REQ-007 ack0 / ack1  output  1  one-cycle pulse: request accepted, n captured.
REQ-008 done0 / done1  output  1  one-cycle pulse: result for that requester valid.
REQ-009 result  output  RW  sum of the last finished job, modulo 2^RW; holds until the next done.
REQ-010 overflow  output  1  high if the last finished job exceeded 2^RW-1; holds with result.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, TEST, ACC and DONE; all outputs SHALL be registered.
REQ-013 IDLE: on an edge with any req high, the block SHALL grant one requester, load cnt <= n_k, acc <= 0, ovf <= 0, owner <= k, and go to TEST with ack_k high for that TEST cycle only.
REQ-014 Arbitration SHALL be round-robin: on a tie, the requester not served last wins; the last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-015 TEST: cnt == 0 SHALL go to DONE; otherwise the FSM SHALL go to ACC.
REQ-016 ACC: acc <= (acc + cnt) mod 2^RW, cnt <= cnt - 1, and ovf is set when the RW+1-bit sum carries out; ovf SHALL be sticky for the job; the FSM SHALL return to TEST.
REQ-017 Entering DONE: result <= acc, overflow <= ovf, and done_owner SHALL be high for that DONE cycle only; last-served <= owner; the FSM SHALL then go to IDLE.
REQ-018 Latency: done SHALL be high in cycle 2n+2 after the accepting edge (cycle 1 = first TEST); n = 0 gives done in cycle 2.
REQ-019 IDLE SHALL last at least one cycle between jobs; back-to-back accepts SHALL be 2n+3 cycles apart.
REQ-020 Requests arriving while busy SHALL wait; they SHALL NOT be captured or acked until IDLE.
REQ-021 A request dropped before its ack SHALL be withdrawn without effect.
REQ-022 req still high after done SHALL be treated as a new request.
REQ-023 ack and done SHALL never be high for both requesters in the same cycle.

Reset
REQ-024 reset low SHALL, immediately and regardless of clock: set state IDLE; clear cnt, acc, ovf, result, overflow, ack0/1, done0/1 and busy; and set last-served to 1.
REQ-025 Reset mid-job SHALL abort the job with no done pulse; the pending request SHALL be lost.

Structure
REQ-026 Package somatorio_pkg SHALL hold the NW and RW defaults and the state encoding (IDLE, TEST, ACC, DONE).
REQ-027 The counter/accumulator SHALL be the sub-module somatorio_dp, controlled by load/dec/acc_en, with outputs zero and carry; arbitration and the FSM SHALL stay in the top module.

Verification
REQ-028 req0=1, n0=4 after reset -> ack0 in cycle 1, done0 in cycle 10, result=10, overflow=0.
REQ-029 req1=1, n1=0 -> ack1 in cycle 1, done1 in cycle 2, result=0, overflow=0.
REQ-030 req0 and req1 both high in the same cycle after reset, n0=3, n1=5 -> job 0 first (result=6), then job 1 acked the cycle after IDLE (result=15); a second tie -> requester 0 served first.
REQ-031 RW=12, n0=100 -> done0 in cycle 202, result=954 (5050 mod 4096), overflow=1; a following job n0=2 -> result=3, overflow=0.
REQ-032 reset pulsed low during ACC of an n0=10 job -> busy, result, overflow, ack and done all 0 at once; no done0 pulse afterwards; a fresh request then completes normally.
